// File: rtl/mil_tx_encoder_if.sv
// Word push channel into the 1553 transmit encoder: one word (type + payload)
// moves per cycle in which in_valid and in_ready are both high.
interface mil_tx_encoder_if;
  logic        in_valid;
  logic [1:0]  in_type;
  logic [15:0] in_word;
  logic        in_ready;

  modport master (output in_valid, output in_type, output in_word, input in_ready);
  modport slave  (input in_valid, input in_type, input in_word, output in_ready);
endinterface

// File: rtl/mil_tx_encoder.sv
// MIL-STD-1553 Manchester II word encoder: sync, 16 data bits and odd parity
// on a differential TXout/nTXout pair, with a one-entry holding register.
//
// state  | meaning
// IDLE   | line 0/0, waiting for a pending word while grant is high
// SYNC   | half-bits 0-5, 3 half-bits high/low or low/high by word type
// DATA   | half-bits 6-37, payload MSB first, a 1 is sent high then low
// PARITY | half-bits 38-39, odd parity (inverted for WERROR)
module mil_tx_encoder #(
  parameter int HALF_BIT_CYCLES = 25
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              grant,
  mil_tx_encoder_if.slave   in_if,
  output logic              TXout,
  output logic              nTXout,
  output logic              busy,
  output logic              word_done
);

  typedef enum logic [1:0] {IDLE, SYNC, DATA, PARITY} state_t;

  localparam int DIV_W = (HALF_BIT_CYCLES > 2) ? $clog2(HALF_BIT_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_BIT_CYCLES - 1);
  localparam logic [1:0] WERROR = 2'd3;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [5:0]        half_q, half_d;
  logic [16:0]       sh_q, sh_d;
  logic [1:0]        type_q, type_d;
  logic              pend_q, pend_d;
  logic [1:0]        htype_q, htype_d;
  logic [15:0]       hword_q, hword_d;
  logic              line_q, line_d;
  logic              act_q, act_d;
  logic              done_q, done_d;
  logic              tick;
  logic              start;

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    half_d  = half_q;
    sh_d    = sh_q;
    type_d  = type_q;
    pend_d  = pend_q;
    htype_d = htype_q;
    hword_d = hword_q;
    done_d  = 1'b0;
    start   = 1'b0;

    case (state_q)
      IDLE: begin
        if (pend_q && grant) start = 1'b1;
      end
      SYNC, DATA, PARITY: begin
        div_d = tick ? '0 : div_q + DIV_W'(1);
        if (tick) begin
          half_d = half_q + 6'd1;
          // Advance to the next payload bit after its second half.
          if (state_q == DATA && half_q[0]) sh_d = {sh_q[15:0], 1'b0};
          if (half_q == 6'd5)  state_d = DATA;
          if (half_q == 6'd37) state_d = PARITY;
          if (half_q == 6'd39) begin
            done_d = 1'b1;
            if (pend_q && grant) start = 1'b1;
            else                 state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d = SYNC;
      div_d   = '0;
      half_d  = '0;
      type_d  = htype_q;
      sh_d    = {hword_q, (~^hword_q) ^ (htype_q == WERROR)};
      pend_d  = 1'b0;
    end

    // Acceptance needs pend_q low, so it never collides with start clearing it.
    if (in_if.in_valid && !pend_q) begin
      pend_d  = 1'b1;
      htype_d = in_if.in_type;
      hword_d = in_if.in_word;
    end

    act_d = (state_d != IDLE);
    case (state_d)
      SYNC:         line_d = (half_d < 6'd3) ? ~type_d[1] : type_d[1];
      DATA, PARITY: line_d = sh_d[16] ^ half_d[0];
      default:      line_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= IDLE;
      div_q   <= '0;
      half_q  <= '0;
      sh_q    <= '0;
      type_q  <= '0;
      pend_q  <= 1'b0;
      htype_q <= '0;
      hword_q <= '0;
      line_q  <= 1'b0;
      act_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      half_q  <= half_d;
      sh_q    <= sh_d;
      type_q  <= type_d;
      pend_q  <= pend_d;
      htype_q <= htype_d;
      hword_q <= hword_d;
      line_q  <= line_d;
      act_q   <= act_d;
      done_q  <= done_d;
    end
  end

  assign in_if.in_ready = ~pend_q;
  assign TXout          = act_q & line_q;
  assign nTXout         = act_q & ~line_q;
  assign busy           = act_q;
  assign word_done      = done_q;

endmodule

// File: tb/tb_mil_tx_encoder.sv
// Randomized bench for mil_tx_encoder against a cycle-count reference model
// that builds each word's 40 half-bits directly from the 1553 framing rules.
module tb_mil_tx_encoder;
  localparam int H    = 3;
  localparam int WLEN = 40 * H;

  logic clk = 1'b0;
  logic nRst = 1'b0;
  logic grant = 1'b0;
  logic TXout, nTXout, busy, word_done;

  int checks = 0;
  int failures = 0;

  mil_tx_encoder_if bus ();

  mil_tx_encoder #(.HALF_BIT_CYCLES(H)) dut (
    .clk       (clk),
    .nRst      (nRst),
    .grant     (grant),
    .in_if     (bus),
    .TXout     (TXout),
    .nTXout    (nTXout),
    .busy      (busy),
    .word_done (word_done)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit        m_pend;
  bit [1:0]  m_ptype;
  bit [15:0] m_pword;
  bit        m_act;
  int        m_cnt;
  bit [1:0]  m_ctype;
  bit [15:0] m_cword;
  bit        m_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit half_bit(input bit [1:0] t, input bit [15:0] w, input int h);
    bit cmd, b, p;
    cmd = (t == 2'd0) || (t == 2'd1);
    if (h < 6) return (h < 3) ? cmd : !cmd;
    if (h < 38) begin
      b = w[15 - (h - 6) / 2];
      return (h % 2 == 0) ? b : !b;
    end
    p = ($countones(w) % 2 == 0);
    if (t == 2'd3) p = !p;
    return (h == 38) ? p : !p;
  endfunction

  task automatic model_reset();
    m_pend = 0; m_ptype = 0; m_pword = 0;
    m_act = 0; m_cnt = 0; m_ctype = 0; m_cword = 0; m_done = 0;
  endtask

  task automatic model_update();
    bit acc, fin, go;
    if (!nRst) begin
      model_reset();
      return;
    end
    acc = bus.in_valid && !m_pend;
    fin = m_act && (m_cnt == WLEN - 1);
    go  = (!m_act || fin) && m_pend && grant;
    m_done = fin;
    if (go) begin
      m_act = 1; m_cnt = 0; m_ctype = m_ptype; m_cword = m_pword; m_pend = 0;
    end else if (fin) begin
      m_act = 0; m_cnt = 0;
    end else if (m_act) begin
      m_cnt++;
    end
    if (acc) begin
      m_pend = 1; m_ptype = bus.in_type; m_pword = bus.in_word;
    end
  endtask

  task automatic compare_all();
    bit e_tx;
    e_tx = m_act ? half_bit(m_ctype, m_cword, m_cnt / H) : 1'b0;
    chk("txout",     32'(TXout),        32'(e_tx));
    chk("ntxout",    32'(nTXout),       32'(m_act ? !e_tx : 1'b0));
    chk("busy",      32'(busy),         32'(m_act));
    chk("word_done", 32'(word_done),    32'(m_done));
    chk("in_ready",  32'(bus.in_ready), 32'(!m_pend));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic push(input bit [1:0] t, input bit [15:0] w);
    bus.in_valid = 1'b1; bus.in_type = t; bus.in_word = w;
    cyc();
    bus.in_valid = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * WLEN && (m_act || m_pend); i++) cyc();
    run(3);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_type = 2'd0; bus.in_word = 16'h0;
    model_reset();
    run(3);
    nRst = 1'b1;
    run(2);

    // Single command word, then back-to-back command + data
    grant = 1'b1;
    push(2'd0, 16'hEFAB);
    drain();
    push(2'd0, 16'hEFAB);
    push(2'd2, 16'h02A1);
    drain();

    // Parity cases: data and error-injected
    push(2'd2, 16'h0001);
    drain();
    push(2'd3, 16'h0001);
    drain();

    // Grant low blocks start; drop grant mid-word, queued word waits
    grant = 1'b0;
    push(2'd1, 16'h1234);
    push(2'd2, 16'h5678);
    run(5);
    grant = 1'b1;
    run(20 * H + 1);
    grant = 1'b0;
    push(2'd0, 16'hA5A5);
    run(2 * WLEN);
    grant = 1'b1;
    drain();

    // Async reset at half-bit 17
    push(2'd0, 16'hC3C3);
    run(17 * H + 1);
    nRst = 1'b0;
    #1;
    chk("rst_txout",    32'(TXout),        32'd0);
    chk("rst_ntxout",   32'(nTXout),       32'd0);
    chk("rst_busy",     32'(busy),         32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    model_reset();
    run(2);
    nRst = 1'b1;
    grant = 1'b0;
    run(2 * WLEN);
    grant = 1'b1;

    // Random traffic with occasional grant drops
    for (int i = 0; i < 6000; i++) begin
      bus.in_valid = ($urandom % 4) != 0;
      bus.in_type  = 2'($urandom);
      bus.in_word  = 16'($urandom);
      grant        = ($urandom % 16) != 0;
      cyc();
    end
    bus.in_valid = 1'b0;
    grant = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
